stopwatch_timebase: RTL and testbench

Parametrised stopwatch core: prescaler, mixed-radix BCD digit chain, start/stop, lap-freeze and clear control in one clock domain.
Replaces the ripple-clocked divider/counter/toggle-latch arrangement with a single-clock design using clock enables.
Feeds the SPI display driver with display digits and the status pins with run/lap state.
Digit count, radix per digit and tick rate are generic.

---
 rtl/stopwatch_timebase_pkg.sv | 13 +
 rtl/stopwatch_timebase_if.sv | 24 ++
 rtl/stopwatch_timebase_bcd_digit.sv | 23 ++
 rtl/stopwatch_timebase.sv | 111 +++++++++++
 tb/tb_stopwatch_timebase.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_timebase_pkg.sv
// stopwatch_timebase_pkg: shared digit width, default timing/layout constants and digit indexing
package stopwatch_timebase_pkg;
    localparam int DIGIT_W = 4;
    localparam int DEFAULT_NUM_DIGITS = 6;
    localparam int DEFAULT_DIV = 10000;
    localparam int DEFAULT_DIV_W = 14;
    // mm:ss:cc layout: digit 0/1 = centiseconds, 2/3 = seconds, 4/5 = minutes; tens of s and min count 0..5
    localparam logic [DEFAULT_NUM_DIGITS-1:0] DEFAULT_RADIX6_MASK = 6'b101000;
    // digit i occupies bits [digit_lsb(i) +: DIGIT_W]; digit 0 is least significant
    function automatic int digit_lsb(input int i);
        return DIGIT_W * i;
    endfunction
endpackage

// File: rtl/stopwatch_timebase_if.sv
// stopwatch_timebase_if: control levels in, count/display/status out
interface stopwatch_timebase_if
    import stopwatch_timebase_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
);
    logic                            start_stop;
    logic                            lap;
    logic                            clear;
    logic [DIGIT_W*NUM_DIGITS-1:0]   live_digits;
    logic [DIGIT_W*NUM_DIGITS-1:0]   disp_digits;
    logic                            running;
    logic                            lap_hold;
    logic                            tick;
    logic                            overflow;
    modport master (
        output start_stop, lap, clear,
        input  live_digits, disp_digits, running, lap_hold, tick, overflow
    );
    modport slave (
        input  start_stop, lap, clear,
        output live_digits, disp_digits, running, lap_hold, tick, overflow
    );
endinterface

// File: rtl/stopwatch_timebase_bcd_digit.sv
// bcd_digit: one clock-enabled BCD digit counting 0..RADIX-1 with synchronous clear
module bcd_digit
    import stopwatch_timebase_pkg::*;
#(
    parameter int RADIX = 10
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic               at_max,
    output logic [DIGIT_W-1:0] value
);
    assign at_max = value == DIGIT_W'(RADIX - 1);
    // clear wins over increment; a digit at max rolls to 0 when incremented
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            value <= '0;
        else if (clr)
            value <= '0;
        else if (inc)
            value <= at_max ? '0 : value + 1'b1;
endmodule

// File: rtl/stopwatch_timebase.sv
// stopwatch_timebase: prescaler + mixed-radix BCD chain with start/stop, lap freeze and clear; define STOPWATCH_SATURATE_EN to hold at max instead of wrapping
module stopwatch_timebase
    import stopwatch_timebase_pkg::*;
#(
    parameter int                    NUM_DIGITS  = DEFAULT_NUM_DIGITS,
    parameter logic [NUM_DIGITS-1:0] RADIX6_MASK = NUM_DIGITS'(DEFAULT_RADIX6_MASK),
    parameter int                    DIV         = DEFAULT_DIV,
    parameter int                    DIV_W       = DEFAULT_DIV_W
)(
    input logic                 clk,
    input logic                 rst_n,
    stopwatch_timebase_if.slave bus
);
    localparam int W = DIGIT_W * NUM_DIGITS;

    logic [2:0]            s1, s2, prev, armed, ev;
    logic                  up;
    logic                  ev_ss, ev_lap, ev_clr, ss_ok;
    logic [DIV_W-1:0]      pre;
    logic                  tick_r, running_r, lap_hold_r, overflow_r;
    logic [W-1:0]          live, lap_reg;
    logic [NUM_DIGITS-1:0] at_max, cy;
    logic                  all_max, wrap, adv;

    // 2-flop synchronisers plus previous-value flops; a level already high when reset releases never arms
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1    <= '0;
            s2    <= '0;
            prev  <= '0;
            armed <= '0;
            up    <= 1'b0;
        end else begin
            s1    <= {bus.clear, bus.lap, bus.start_stop};
            s2    <= s1;
            prev  <= s2;
            up    <= 1'b1;
            armed <= armed | ({3{up}} & ~s1);
        end

    assign ev     = s2 & ~prev & armed;
    assign ev_ss  = ev[0];
    assign ev_lap = ev[1];
    assign ev_clr = ev[2];

    assign all_max = &at_max;
    assign wrap    = tick_r & all_max;
`ifdef STOPWATCH_SATURATE_EN
    assign adv   = tick_r & ~all_max;
    assign ss_ok = ev_ss & ~overflow_r;
`else
    assign adv   = tick_r;
    assign ss_ok = ev_ss;
`endif

    assign cy[0] = adv;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        if (i > 0) begin : g_cy
            assign cy[i] = cy[i-1] & at_max[i-1];
        end
        bcd_digit #(.RADIX(RADIX6_MASK[i] ? 6 : 10)) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (ev_clr),
            .inc    (cy[i]),
            .at_max (at_max[i]),
            .value  (live[digit_lsb(i) +: DIGIT_W])
        );
    end

    // prescaler, run/lap state and sticky overflow; clear beats start_stop/lap, which are applied alongside a pending tick
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pre        <= '0;
            tick_r     <= 1'b0;
            running_r  <= 1'b0;
            lap_hold_r <= 1'b0;
            lap_reg    <= '0;
            overflow_r <= 1'b0;
        end else if (ev_clr) begin
            pre        <= '0;
            tick_r     <= 1'b0;
            running_r  <= 1'b0;
            lap_hold_r <= 1'b0;
            lap_reg    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (running_r)
                pre <= (pre == DIV_W'(DIV - 1)) ? '0 : pre + 1'b1;
            tick_r <= running_r && (pre == DIV_W'(DIV - 1));
`ifdef STOPWATCH_SATURATE_EN
            running_r <= wrap ? 1'b0 : running_r ^ ss_ok;
`else
            running_r <= running_r ^ ss_ok;
`endif
            if (ev_lap) begin
                lap_hold_r <= ~lap_hold_r;
                if (!lap_hold_r)
                    lap_reg <= live;
            end
            if (wrap)
                overflow_r <= 1'b1;
        end

    assign bus.live_digits = live;
    assign bus.disp_digits = lap_hold_r ? lap_reg : live;
    assign bus.running     = running_r;
    assign bus.lap_hold    = lap_hold_r;
    assign bus.tick        = tick_r;
    assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_stopwatch_timebase.sv
// tb_stopwatch_timebase: directed vectors for counting/carries plus hand sequences for wrap, lap, clear and reset
module tb_stopwatch_timebase;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    stopwatch_timebase_if #(.NUM_DIGITS(6)) m_if();
    stopwatch_timebase_if #(.NUM_DIGITS(3)) w_if();

    stopwatch_timebase #(.NUM_DIGITS(6), .RADIX6_MASK(6'b101000), .DIV(4), .DIV_W(3)) u_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if)
    );

    stopwatch_timebase #(.NUM_DIGITS(3), .RADIX6_MASK(3'b100), .DIV(1), .DIV_W(1)) u_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (w_if)
    );

    typedef struct {
        int          k;
        logic [23:0] live;
        logic        tick;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   failures = 0;
    int   cur = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic adv_to(input int k);
        while (cur < k) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            0: m_if.start_stop = 1'b1;
            1: m_if.lap = 1'b1;
            2: m_if.clear = 1'b1;
            default: w_if.start_stop = 1'b1;
        endcase
        @(negedge clk);
        cur++;
        m_if.start_stop = 1'b0;
        m_if.lap = 1'b0;
        m_if.clear = 1'b0;
        w_if.start_stop = 1'b0;
    endtask

    // running must rise exactly on the third edge after the input is first sampled; cur=0 there
    task automatic start_run(input int which);
        pulse(which);
        @(negedge clk);
        chk("run_not_yet", which == 3 ? w_if.running : m_if.running, 1'b0);
        @(negedge clk);
        chk("run_started", which == 3 ? w_if.running : m_if.running, 1'b1);
        cur = 0;
    endtask

    initial begin
        m_if.start_stop = 1'b0;
        m_if.lap = 1'b0;
        m_if.clear = 1'b0;
        w_if.start_stop = 1'b0;
        vecs[0] = '{1,     24'h000000, 1'b0};
        vecs[1] = '{4,     24'h000000, 1'b1};
        vecs[2] = '{5,     24'h000001, 1'b0};
        vecs[3] = '{8,     24'h000001, 1'b1};
        vecs[4] = '{9,     24'h000002, 1'b0};
        vecs[5] = '{3997,  24'h000999, 1'b0};
        vecs[6] = '{4000,  24'h000999, 1'b1};
        vecs[7] = '{4001,  24'h001000, 1'b0};
        vecs[8] = '{23997, 24'h005999, 1'b0};
        vecs[9] = '{24001, 24'h010000, 1'b0};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_live", m_if.live_digits, 0);
        chk("rst_disp", m_if.disp_digits, 0);
        chk("rst_running", m_if.running, 0);
        chk("rst_lap_hold", m_if.lap_hold, 0);
        chk("rst_tick", m_if.tick, 0);
        chk("rst_overflow", m_if.overflow, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // full-range wrap on a 3-digit 5:9:9 chain ticking every cycle
        start_run(3);
        adv_to(600);
        chk("w_max_live", w_if.live_digits, 12'h599);
        chk("w_max_ovf", w_if.overflow, 0);
        adv_to(601);
`ifdef STOPWATCH_SATURATE_EN
        chk("w_sat_live", w_if.live_digits, 12'h599);
        chk("w_sat_run", w_if.running, 0);
        chk("w_sat_ovf", w_if.overflow, 1);
        adv_to(602);
        chk("w_sat_hold", w_if.live_digits, 12'h599);
        pulse(3);
        adv_to(610);
        chk("w_sat_ss_ignored", w_if.running, 0);
        chk("w_sat_hold2", w_if.live_digits, 12'h599);
`else
        chk("w_wrap_live", w_if.live_digits, 12'h000);
        chk("w_wrap_ovf", w_if.overflow, 1);
        chk("w_wrap_run", w_if.running, 1);
        adv_to(602);
        chk("w_after_live", w_if.live_digits, 12'h001);
        chk("w_after_ovf", w_if.overflow, 1);
`endif

        // main counting vectors, DIV=4
        start_run(0);
        for (int i = 0; i < 10; i++) begin
            adv_to(vecs[i].k);
            chk($sformatf("vec%0d_live", i), m_if.live_digits, vecs[i].live);
            chk($sformatf("vec%0d_disp", i), m_if.disp_digits, vecs[i].live);
            chk($sformatf("vec%0d_tick", i), m_if.tick, vecs[i].tick);
            chk($sformatf("vec%0d_run", i), m_if.running, 1);
            chk($sformatf("vec%0d_ovf", i), m_if.overflow, 0);
        end

        // clear while running
        pulse(2);
        repeat (2) @(negedge clk);
        chk("clr_live", m_if.live_digits, 0);
        chk("clr_run", m_if.running, 0);
        chk("clr_tick", m_if.tick, 0);
        repeat (8) @(negedge clk);
        chk("clr_stays", m_if.live_digits, 0);

        // lap capture, including lap landing on an increment edge
        start_run(0);
        adv_to(493);
        chk("lap_pre_live", m_if.live_digits, 24'h000123);
        adv_to(494);
        pulse(1);
        adv_to(497);
        chk("lap_live", m_if.live_digits, 24'h000124);
        chk("lap_disp", m_if.disp_digits, 24'h000123);
        chk("lap_hold", m_if.lap_hold, 1);
        adv_to(801);
        chk("lap_live200", m_if.live_digits, 24'h000200);
        chk("lap_frozen", m_if.disp_digits, 24'h000123);
        pulse(1);
        adv_to(804);
        chk("unlap_hold", m_if.lap_hold, 0);
        chk("unlap_disp", m_if.disp_digits, 24'h000200);
        pulse(1);
        adv_to(1026);
        chk("lap2_hold", m_if.lap_hold, 1);
        chk("lap2_disp", m_if.disp_digits, 24'h000201);
        chk("lap2_live", m_if.live_digits, 24'h000256);

        // clear together with start_stop, landing on an increment edge
        m_if.clear = 1'b1;
        m_if.start_stop = 1'b1;
        @(negedge clk);
        cur++;
        m_if.clear = 1'b0;
        m_if.start_stop = 1'b0;
        adv_to(1029);
        chk("cs_live", m_if.live_digits, 0);
        chk("cs_disp", m_if.disp_digits, 0);
        chk("cs_run", m_if.running, 0);
        chk("cs_lap_hold", m_if.lap_hold, 0);
        chk("cs_ovf", m_if.overflow, 0);
        adv_to(1040);
        chk("cs_no_toggle", m_if.running, 0);
        chk("cs_live_held", m_if.live_digits, 0);

        // asynchronous reset mid-count, start_stop held high across release
        start_run(0);
        adv_to(50);
        chk("mid_live", m_if.live_digits, 24'h000012);
        #3 rst_n = 1'b0;
        m_if.start_stop = 1'b1;
        #1;
        chk("arst_live", m_if.live_digits, 0);
        chk("arst_disp", m_if.disp_digits, 0);
        chk("arst_run", m_if.running, 0);
        chk("arst_tick", m_if.tick, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("held_no_start", m_if.running, 0);
        chk("held_live", m_if.live_digits, 0);
        m_if.start_stop = 1'b0;
        repeat (4) @(negedge clk);
        start_run(0);
        adv_to(5);
        chk("restart_live", m_if.live_digits, 24'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
